// File: rtl/pix_dispatch_pkg.sv
// Shared types and defaults for the pixel work dispatcher.
package pix_dispatch_pkg;

    localparam int unsigned FX_WIDTH_DEFAULT = 32;
    localparam int unsigned FRAC_DEFAULT     = 28;

    // Signed fixed-point value, Q4.28 at the default width/fraction.
    typedef logic signed [FX_WIDTH_DEFAULT-1:0] fx_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } dispatch_state_t;

endpackage

// File: rtl/pix_coord_map.sv
// Maps an integer pixel coordinate to its fixed-point complex seed.
// Pure combinational so a host-side readback checker can reuse it.
module pix_coord_map #(
    parameter int unsigned CNT_BITS = 10,
    parameter int unsigned WIDTH    = 32
) (
    input  logic        [CNT_BITS-1:0] x,
    input  logic        [CNT_BITS-1:0] y,
    input  logic signed [WIDTH-1:0]    re_min,
    input  logic signed [WIDTH-1:0]    re_step,
    input  logic signed [WIDTH-1:0]    im_max,
    input  logic signed [WIDTH-1:0]    im_step,
    output logic signed [WIDTH-1:0]    c_re,
    output logic signed [WIDTH-1:0]    c_im
);

    if (CNT_BITS > WIDTH) begin : g_width_check
        $error("CNT_BITS must not exceed WIDTH");
    end

    logic [WIDTH-1:0] x_ext;
    logic [WIDTH-1:0] y_ext;
    logic [WIDTH-1:0] x_prod;
    logic [WIDTH-1:0] y_prod;

    // Coordinates are plain integers, so only the low WIDTH bits of the
    // products matter; a WIDTH x WIDTH multiply yields exactly those bits
    // and overflow wraps in two's complement.
    always_comb begin
        x_ext  = {{(WIDTH-CNT_BITS){1'b0}}, x};
        y_ext  = {{(WIDTH-CNT_BITS){1'b0}}, y};
        x_prod = x_ext * re_step;
        y_prod = y_ext * im_step;
        c_re   = re_min + x_prod;
        c_im   = im_max - y_prod;
    end

endmodule

// File: rtl/pix_dispatch.sv
// Frame-level issuer: steps the external pixel counter and presents each
// pixel with its complex seed over a valid/ready output slot.
module pix_dispatch
    import pix_dispatch_pkg::*;
#(
    parameter int unsigned CNT_BITS = 10,
    parameter int unsigned WIDTH    = FX_WIDTH_DEFAULT,
    parameter int unsigned FRAC     = FRAC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic        [CNT_BITS-1:0] x_max,
    input  logic        [CNT_BITS-1:0] y_max,
    input  logic signed [WIDTH-1:0]    re_min,
    input  logic signed [WIDTH-1:0]    im_max,
    input  logic signed [WIDTH-1:0]    re_step,
    input  logic signed [WIDTH-1:0]    im_step,
    output logic                       cnt_clear,
    output logic                       cnt_enable,
    input  logic        [CNT_BITS-1:0] x_value,
    input  logic        [CNT_BITS-1:0] y_value,
    input  logic                       cnt_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic        [CNT_BITS-1:0] out_x,
    output logic        [CNT_BITS-1:0] out_y,
    output logic signed [WIDTH-1:0]    out_c_re,
    output logic signed [WIDTH-1:0]    out_c_im,
    output logic                       busy,
    output logic                       frame_done
);

    if (FRAC >= WIDTH) begin : g_frac_check
        $error("FRAC must be smaller than WIDTH");
    end

    // Frame bounds only matter to the counter, which owns the wrap logic.
    logic unused_bounds;
    assign unused_bounds = ^{x_max, y_max};

    dispatch_state_t    state;
    logic               load;
    logic signed [WIDTH-1:0] c_re;
    logic signed [WIDTH-1:0] c_im;

    pix_coord_map #(
        .CNT_BITS (CNT_BITS),
        .WIDTH    (WIDTH)
    ) u_coord_map (
        .x       (x_value),
        .y       (y_value),
        .re_min  (re_min),
        .re_step (re_step),
        .im_max  (im_max),
        .im_step (im_step),
        .c_re    (c_re),
        .c_im    (c_im)
    );

    // Slot can take a new pixel when empty or draining this cycle; counter
    // steps only alongside a load so no pixel is skipped or repeated.
    always_comb begin
        load       = !out_valid || out_ready;
        cnt_clear  = (state == IDLE);
        cnt_enable = (state == RUN) && load && !cnt_done;
        busy       = (state != IDLE);
    end

    // Dispatch FSM with registered output slot and frame_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_c_re   <= '0;
            out_c_im   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        out_x     <= x_value;
                        out_y     <= y_value;
                        out_c_re  <= c_re;
                        out_c_im  <= c_im;
                        out_valid <= 1'b1;
                        if (cnt_done) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pix_dispatch.sv
// Self-checking bench for pix_dispatch: models the pixel counter, runs a
// table of frames against a scoreboard, plus reset/start corner sequences.
module tb_pix_dispatch;
    import pix_dispatch_pkg::*;

    localparam int CB = 10;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CB-1:0] x_max, y_max;
    logic [W-1:0]  re_min, im_max, re_step, im_step;
    logic          cnt_clear, cnt_enable, cnt_done;
    logic [CB-1:0] x_value, y_value;
    logic          out_valid, out_ready;
    logic [CB-1:0] out_x, out_y;
    logic [W-1:0]  out_c_re, out_c_im;
    logic          busy, frame_done;

    always #5 clk = ~clk;

    pix_dispatch #(
        .CNT_BITS (CB),
        .WIDTH    (W),
        .FRAC     (28)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x_max      (x_max),
        .y_max      (y_max),
        .re_min     (re_min),
        .im_max     (im_max),
        .re_step    (re_step),
        .im_step    (im_step),
        .cnt_clear  (cnt_clear),
        .cnt_enable (cnt_enable),
        .x_value    (x_value),
        .y_value    (y_value),
        .cnt_done   (cnt_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_c_re   (out_c_re),
        .out_c_im   (out_c_im),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Pixel counter model: raster order, x first.
    always @(posedge clk) begin
        if (rst || cnt_clear) begin
            x_value <= '0;
            y_value <= '0;
        end else if (cnt_enable) begin
            if (x_value == x_max) begin
                x_value <= '0;
                y_value <= y_value + 1'b1;
            end else begin
                x_value <= x_value + 1'b1;
            end
        end
    end
    assign cnt_done = (x_value == x_max) && (y_value == y_max);

    typedef struct {
        logic [CB-1:0] x;
        logic [CB-1:0] y;
        logic [W-1:0]  re;
        logic [W-1:0]  im;
    } pix_t;

    typedef struct {
        logic [CB-1:0] xm;
        logic [CB-1:0] ym;
        logic [W-1:0]  rmin;
        logic [W-1:0]  rstep;
        logic [W-1:0]  imax;
        logic [W-1:0]  istep;
        int            mode;     // 0: always ready, 1: random with 5-cycle stalls
        int            restart;  // transfer index at which to re-pulse start, -1 none
        int            count;
        int            spot;
        logic [W-1:0]  sre;
        logic [W-1:0]  sim;
    } frame_t;

    pix_t   exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     nxfer = 0;
    int     last_xfer_cyc = 0;
    int     fd_cnt = 0;
    logic   mon_en = 1'b0;
    logic   tput = 1'b0;
    logic   stalled_prev = 1'b0;
    pix_t   held;
    int     spot_idx = -1;
    logic [W-1:0] spot_re, spot_im;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic pix_t model(input int x, input int y);
        pix_t m;
        logic [W-1:0] xe, ye;
        xe   = W'(x);
        ye   = W'(y);
        m.x  = CB'(x);
        m.y  = CB'(y);
        m.re = re_min + xe * re_step;
        m.im = im_max - ye * im_step;
        return m;
    endfunction

    // Monitor: scoreboard pops on transfer, stall stability, frame_done timing.
    always @(negedge clk) begin
        pix_t e;
        cyc++;
        if (!rst && mon_en) begin
            if (stalled_prev) begin
                check("stall_hold_xy", {out_x, out_y}, {held.x, held.y});
                check("stall_hold_re", out_c_re, held.re);
                check("stall_hold_im", out_c_im, held.im);
            end
            if (out_valid && !out_ready) begin
                check("stall_no_enable", cnt_enable, 1'b0);
                stalled_prev = 1'b1;
                held = '{out_x, out_y, out_c_re, out_c_im};
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_pixel: got (%0d,%0d) expected none", out_x, out_y);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_xy", {out_x, out_y}, {e.x, e.y});
                    check("pix_re", out_c_re, e.re);
                    check("pix_im", out_c_im, e.im);
                end
                if (nxfer == spot_idx) begin
                    check("spot_re", out_c_re, spot_re);
                    check("spot_im", out_c_im, spot_im);
                end
                if (tput && nxfer > 0) check("throughput_gap", cyc - last_xfer_cyc, 1);
                last_xfer_cyc = cyc;
                nxfer++;
            end
            if (frame_done) begin
                fd_cnt++;
                check("done_after_last", cyc - last_xfer_cyc, 1);
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic run_frame(input frame_t f);
        int   ccount;
        logic restarted;
        x_max   = f.xm;
        y_max   = f.ym;
        re_min  = f.rmin;
        re_step = f.rstep;
        im_max  = f.imax;
        im_step = f.istep;
        spot_idx = f.spot;
        spot_re  = f.sre;
        spot_im  = f.sim;
        tput     = (f.mode == 0);
        for (int y = 0; y <= int'(f.ym); y++)
            for (int x = 0; x <= int'(f.xm); x++)
                exp_q.push_back(model(x, y));
        nxfer     = 0;
        fd_cnt    = 0;
        mon_en    = 1'b1;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("lat_busy", busy, 1'b1);
        check("lat_not_valid_yet", out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_first_valid", out_valid, 1'b1);
        check("lat_first_xy", {out_x, out_y}, '0);
        ccount    = 0;
        restarted = 1'b0;
        while (fd_cnt == 0 && ccount < 400) begin
            if (f.mode == 0) out_ready = 1'b1;
            else if ((ccount % 13) >= 3 && (ccount % 13) <= 7) out_ready = 1'b0;
            else out_ready = 1'($urandom_range(0, 1));
            if (f.restart >= 0 && nxfer == f.restart && !restarted) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            ccount++;
        end
        if (fd_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no frame_done after %0d cycles, required one", ccount);
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("frame_done_once", fd_cnt, 1);
        check("pixel_count", nxfer, f.count);
        check("queue_empty", exp_q.size(), 0);
        check("idle_busy", busy, 1'b0);
        check("idle_clear", cnt_clear, 1'b1);
    endtask

    frame_t frames[5];

    initial begin
        frames[0] = '{10'd3, 10'd2, 32'hE0000000, 32'h04000000, 32'h10000000, 32'h08000000,
                      0, -1, 12, 3, 32'hEC000000, 32'h10000000};
        frames[1] = '{10'd3, 10'd2, 32'hE0000000, 32'h04000000, 32'h10000000, 32'h08000000,
                      1, -1, 12, 8, 32'hE0000000, 32'h00000000};
        frames[2] = '{10'd3, 10'd2, 32'hE0000000, 32'h04000000, 32'h10000000, 32'h08000000,
                      0, 5, 12, 11, 32'hEC000000, 32'h00000000};
        frames[3] = '{10'd0, 10'd0, 32'h12345678, 32'h11111111, 32'hF0000000, 32'h22222222,
                      0, -1, 1, 0, 32'h12345678, 32'hF0000000};
        frames[4] = '{10'd1, 10'd0, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h00000001,
                      1, -1, 2, 1, 32'h80000000, 32'h00000000};

        rst = 1'b1; start = 1'b1; out_ready = 1'b1;
        x_max = '0; y_max = '0;
        re_min = '0; re_step = '0; im_max = '0; im_step = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_clear", cnt_clear, 1'b1);
        check("rst_enable", cnt_enable, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_out", {out_x, out_y, out_c_re}, '0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
        check("rst_beats_start", busy, 1'b0);

        for (int i = 0; i < 5; i++) run_frame(frames[i]);

        // Reset mid-frame with a pixel held in the slot.
        mon_en  = 1'b0;
        x_max   = 10'd3;
        y_max   = 10'd2;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_pre_valid", out_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_clear", cnt_clear, 1'b1);
        check("mid_rst_done", frame_done, 1'b0);
        fd_cnt = 0;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_no_done", fd_cnt, 0);
        run_frame(frames[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
